mem_access_stage: RTL

- MEM stage: consumes the EX/MEM pipeline register outputs, performs load/store through a valid/ready data-memory port, and produces write-back data for the MEM/WB register.
- Asserts a stall back to hazard control while an access is outstanding.
- Holds returned load data if MEM/WB is stalled.
- Memory bus is 64-bit, doubleword-addressed, with byte-lane mask.

---
 rtl/mem_access_stage_pkg.sv | 30 +++
 rtl/mem_access_stage_lane_align.sv | 56 +++++
 rtl/mem_access_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage and its byte-lane helper.
package mem_access_stage_pkg;

   // Access sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   // Bit positions inside the one-hot width fields.
   localparam int SZ_B        = 0;
   localparam int SZ_H        = 1;
   localparam int SZ_W        = 2;
   localparam int SZ_D        = 3;
   localparam int RD_UNSIGNED = 5;

   // Byte-lane masks for a naturally aligned access at lane 0.
   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   // Bit shift amount that moves byte 0 onto byte lane 'lane'.
   function automatic logic [5:0] lane_shamt(input logic [2:0] lane);
      return {lane, 3'b000};
   endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Combinational byte-lane steering for a 64-bit doubleword-addressed bus:
// store mask/data placement, load extraction with sign/zero extension,
// and natural-alignment checking.
module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic [2:0]  addr_lo_i,
   input  logic        ram_we_i,
   input  logic        ram_re_i,
   input  logic [3:0]  w_wdth_i,
   input  logic [3:0]  r_size_i,
   input  logic        r_unsigned_i,
   input  logic [63:0] wdata_i,
   input  logic [63:0] rdata_i,
   output logic [7:0]  wmask_o,
   output logic [63:0] wdata_o,
   output logic [63:0] load_o,
   output logic        misalign_o
);

   logic [3:0]  size;
   logic [63:0] rshift;

   // Alignment check against the size of whichever access is requested; a store wins.
   always_comb begin
      size       = ram_we_i ? w_wdth_i : r_size_i;
      misalign_o = (ram_we_i | ram_re_i) &
                   ((size[SZ_H] & addr_lo_i[0])        |
                    (size[SZ_W] & (|addr_lo_i[1:0]))   |
                    (size[SZ_D] & (|addr_lo_i)));
   end

   // Store placement: mask and data moved up to the addressed byte lane.
   always_comb begin
      // NOTE: every output is given a default first so no branch can infer a latch.
      wmask_o = '0;
      if (w_wdth_i[SZ_D])      wmask_o = MASK_D;
      else if (w_wdth_i[SZ_W]) wmask_o = MASK_W << addr_lo_i;
      else if (w_wdth_i[SZ_H]) wmask_o = MASK_H << addr_lo_i;
      else if (w_wdth_i[SZ_B]) wmask_o = MASK_B << addr_lo_i;
      wdata_o = wdata_i << lane_shamt(addr_lo_i);
   end

   // Load extraction: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      rshift = rdata_i >> lane_shamt(addr_lo_i);
      load_o = rshift;
      if (r_size_i[SZ_B])
         load_o = r_unsigned_i ? {56'b0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
      else if (r_size_i[SZ_H])
         load_o = r_unsigned_i ? {48'b0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
      else if (r_size_i[SZ_W])
         load_o = r_unsigned_i ? {32'b0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
   end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a valid/ready memory port,
// stalls upstream while an access is outstanding, and holds the returned
// load data until the MEM/WB register is free to take it.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [63:0]       pc_i,
   input  logic [31:0]       inst_i,
   input  logic              commite_i,
   input  logic [ADDR_W-1:0] result_i,
   input  logic [63:0]       wdata_exu_reg_i,
   input  logic              ram_we_i,
   input  logic [DATA_W-1:0] ram_wdata_i,
   input  logic [3:0]        mem_w_wdth_i,
   input  logic              ram_re_i,
   input  logic [5:0]        mem_r_wdth_i,
   input  logic              reg_we_i,
   input  logic [4:0]        reg_waddr_i,
   input  logic [63:0]       wdate_csr_reg_i,
   input  logic              mem_wb_stall_i,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic              req_we_o,
   output logic [DATA_W-1:0] req_wdata_o,
   output logic [7:0]        req_wmask_o,
   input  logic              rsp_valid_i,
   input  logic [DATA_W-1:0] rsp_rdata_i,
   output logic              mem_stall_o,
   output logic              misalign_o,
   output logic [63:0]       pc_o,
   output logic [31:0]       inst_o,
   output logic              commite_o,
   output logic              reg_we_o,
   output logic [4:0]        reg_waddr_o,
   output logic [63:0]       reg_wdata_o,
   output logic [63:0]       wdate_csr_reg_o
);

   mem_state_e        state_q;
   logic [DATA_W-1:0] load_q;
   logic              access;
   logic [7:0]        wmask;
   logic [DATA_W-1:0] wdata_sh;
   logic [DATA_W-1:0] load_ext;

   // The reserved read-width bit carries no meaning in this stage.
   logic unused_rd_rsvd;
   assign unused_rd_rsvd = mem_r_wdth_i[4];

   mem_lane_align u_align (
      .addr_lo_i    (result_i[2:0]),
      .ram_we_i     (ram_we_i),
      .ram_re_i     (ram_re_i),
      .w_wdth_i     (mem_w_wdth_i),
      .r_size_i     (mem_r_wdth_i[3:0]),
      .r_unsigned_i (mem_r_wdth_i[RD_UNSIGNED]),
      .wdata_i      (ram_wdata_i),
      .rdata_i      (rsp_rdata_i),
      .wmask_o      (wmask),
      .wdata_o      (wdata_sh),
      .load_o       (load_ext),
      .misalign_o   (misalign_o)
   );

   assign access = (ram_re_i | ram_we_i) & ~misalign_o;

   // Access sequencer and load-data buffer.
   always_ff @(posedge clk) begin
      // NOTE: rst_n is an active-high synchronous reset; state is only ever updated with <=.
      if (rst_n) begin
         state_q <= ST_IDLE;
         load_q  <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: if (access) state_q <= req_ready_i ? ST_WAIT : ST_REQ;
            ST_REQ:  if (req_ready_i) state_q <= ST_WAIT;
            ST_WAIT: if (rsp_valid_i) begin
                        load_q  <= ram_we_i ? '0 : load_ext;
                        state_q <= ST_DONE;
                     end
            ST_DONE: if (!mem_wb_stall_i) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Memory request port: address/data come straight from the held EX/MEM inputs.
   always_comb begin
      req_valid_o = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ);
      req_addr_o  = {result_i[ADDR_W-1:3], 3'b000};
      req_we_o    = ram_we_i;
      req_wdata_o = wdata_sh;
      req_wmask_o = ram_we_i ? wmask : 8'h00;
   end

   // Stall and MEM/WB-facing outputs; stall drops in DONE so EX/MEM advances as DONE exits.
   always_comb begin
      mem_stall_o     = access & (state_q != ST_DONE);
      commite_o       = commite_i & ~mem_stall_o;
      reg_we_o        = reg_we_i & ~mem_stall_o & ~misalign_o;
      reg_wdata_o     = ram_re_i ? load_q : wdata_exu_reg_i;
      pc_o            = pc_i;
      inst_o          = inst_i;
      reg_waddr_o     = reg_waddr_i;
      wdate_csr_reg_o = wdate_csr_reg_i;
   end

endmodule
